// File: rtl/uartprobe_pkg.sv
// uartprobe_pkg: shared FSM state encodings and default bit timing for the UART probe
package uartprobe_pkg;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
endpackage

// File: rtl/uartprobe_sync2.sv
// uartprobe_sync2: two-flop synchronizer with parameterised reset value
module uartprobe_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic areset,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  always_ff @(posedge clk or posedge areset)
    if (areset) {o_q, r_meta} <= {2{RST_VAL}};
    else {o_q, r_meta} <= {r_meta, i_d};
endmodule

// File: rtl/uartprobe_uart_rx.sv
// uartprobe_uart_rx: 8-bit UART receiver with single-entry holding register and error pulses.
// Define UARTPROBE_RX_PARITY_EN to add an even-parity bit between data and stop.
module uartprobe_uart_rx
  import uartprobe_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       uart_rx,
  input  logic       rx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       parity_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic w_rx_s, r_rx_prev, w_mid, w_stop, w_good;
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  uartprobe_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .areset(areset), .i_d(uart_rx), .o_q(w_rx_s));
  assign w_mid = r_cnt == LAST;
  assign w_stop = r_state == ST_STOP && w_mid;
`ifdef UARTPROBE_RX_PARITY_EN
  localparam state_t AFTER_DATA = ST_PARITY;
  logic r_par_bad;
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      r_par_bad <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (r_state == ST_PARITY && w_mid) r_par_bad <= w_rx_s ^ (^r_shift);
      parity_err <= w_stop && r_par_bad;
    end
  assign w_good = w_stop && w_rx_s && !r_par_bad;
`else
  localparam state_t AFTER_DATA = ST_STOP;
  assign parity_err = 1'b0;
  assign w_good = w_stop && w_rx_s;
`endif
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_rx_prev <= 1'b1;
      framing_err <= 1'b0;
    end else begin
      r_rx_prev <= w_rx_s;
      framing_err <= 1'b0;
      case (r_state)
        ST_IDLE: if (r_rx_prev && !w_rx_s) begin
          r_state <= ST_START;
          r_cnt <= '0;
        end
        // Mid-start check rejects short low glitches silently
        ST_START: if (r_cnt == HALF) begin
          r_state <= w_rx_s ? ST_IDLE : ST_DATA;
          r_cnt <= '0;
          r_bit <= '0;
        end else r_cnt <= r_cnt + 1'b1;
        ST_DATA: if (w_mid) begin
          r_cnt <= '0;
          r_shift <= {w_rx_s, r_shift[7:1]};
          r_bit <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_state <= AFTER_DATA;
        end else r_cnt <= r_cnt + 1'b1;
`ifdef UARTPROBE_RX_PARITY_EN
        ST_PARITY: if (w_mid) begin
          r_cnt <= '0;
          r_state <= ST_STOP;
        end else r_cnt <= r_cnt + 1'b1;
`endif
        ST_STOP: if (w_mid) begin
          r_cnt <= '0;
          r_state <= ST_IDLE;
          framing_err <= !w_rx_s;
        end else r_cnt <= r_cnt + 1'b1;
        default: r_state <= ST_IDLE;
      endcase
    end
  // A pop in the same cycle frees the slot, so the new byte loads without overrun
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      rx_valid <= 1'b0;
      rx_data <= 8'h00;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= w_good && rx_valid && !rx_ready;
      if (w_good && (!rx_valid || rx_ready)) begin
        rx_valid <= 1'b1;
        rx_data <= r_shift;
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
    end
endmodule

// File: tb/tb_uartprobe_uart_rx.sv
// tb_uartprobe_uart_rx: scoreboard bench driving serial frames against a byte-level receive model
module tb_uartprobe_uart_rx;
  localparam int CPB = 16;
`ifdef UARTPROBE_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  logic clk = 1'b0, areset = 1'b1, uart_rx = 1'b1, rx_ready = 1'b1;
  logic rx_valid, framing_err, overrun_err, parity_err;
  logic [7:0] rx_data;
  int vectors = 0, miscompares = 0;
  int fe_cnt = 0, oe_cnt = 0, pe_cnt = 0, exp_fe = 0, exp_oe = 0, exp_pe = 0, valid_cycles = 0;
  logic [7:0] exp_q[$];
  bit m_full = 1'b0, hold_chk = 1'b0;
  logic [7:0] held = 8'h00;

  uartprobe_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .areset(areset), .uart_rx(uart_rx), .rx_ready(rx_ready), .rx_valid(rx_valid),
    .rx_data(rx_data), .framing_err(framing_err), .overrun_err(overrun_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    uart_rx = b;
    tick(CPB);
  endtask

  // Byte-level model: a good byte lands in a one-deep slot, or is lost as an overrun
  task automatic model(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    if (!stop_ok) exp_fe++;
    if (!par_ok) exp_pe++;
    if (stop_ok && par_ok) begin
      if (m_full) exp_oe++;
      else begin
        exp_q.push_back(d);
        m_full = !rx_ready;
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input bit stop, input bit par, input int gap);
    bit par_ok;
    par_ok = !PAR_EN || (par == ^d);
    model(d, stop, par_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par);
    drive_bit(stop);
    uart_rx = 1'b1;
    tick(gap);
  endtask

  always @(negedge clk) begin
    if (areset) hold_chk = 1'b0;
    else begin
      if (framing_err) fe_cnt++;
      if (overrun_err) oe_cnt++;
      if (parity_err) pe_cnt++;
      if (rx_valid) valid_cycles++;
      if (hold_chk) begin
        check("hold_valid", rx_valid, 1);
        check("hold_data", rx_data, held);
      end
      hold_chk = rx_valid && !rx_ready;
      held = rx_data;
      if (rx_valid && rx_ready) begin
        check("pop_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("pop_data", rx_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    tick(3);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_fe", framing_err, 0);
    check("rst_oe", overrun_err, 0);
    check("rst_pe", parity_err, 0);
    areset = 1'b0;
    tick(5);
    valid_cycles = 0;
    send(8'h5A, 1'b1, 1'b0, 20);
    check("single_valid_width", valid_cycles, 1);
    check("single_fe", fe_cnt, 0);
    check("single_oe", oe_cnt, 0);
    check("single_pe", pe_cnt, 0);
    rx_ready = 1'b0;
    send(8'h11, 1'b1, 1'b0, 5);
    send(8'h22, 1'b1, 1'b0, 20);
    check("ovr_held_valid", rx_valid, 1);
    check("ovr_held_data", rx_data, 8'h11);
    check("ovr_pulse", oe_cnt, 1);
    rx_ready = 1'b1;
    m_full = 1'b0;
    tick(5);
    check("ovr_drained", rx_valid, 0);
    valid_cycles = 0;
    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    tick(40);
    check("glitch_valid", valid_cycles, 0);
    check("glitch_fe", fe_cnt, 0);
    valid_cycles = 0;
    send(8'hA5, 1'b0, 1'b0, 20);
    check("frm_valid", valid_cycles, 0);
    check("frm_pulse", fe_cnt, 1);
    send(8'h3C, 1'b1, 1'b0, 20);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    tick(8);
    areset = 1'b1;
    tick(2);
    check("midrst_valid", rx_valid, 0);
    areset = 1'b0;
    tick(200);
    send(8'h01, 1'b1, 1'b1, 20);
    if (PAR_EN) begin
      send(8'h07, 1'b1, 1'b0, 20);
      check("par_bad_pulse", pe_cnt, 1);
      send(8'h07, 1'b1, 1'b1, 20);
    end
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      bit stop, par;
      d = 8'($urandom);
      stop = $urandom_range(0, 4) != 0;
      par = ($urandom_range(0, 4) != 0) ? ^d : ~^d;
      send(d, stop, par, $urandom_range(2, 20));
    end
    tick(50);
    check("queue_empty", exp_q.size(), 0);
    check("fe_total", fe_cnt, exp_fe);
    check("oe_total", oe_cnt, exp_oe);
    check("pe_total", pe_cnt, exp_pe);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
